// File: rtl/pipelined_mux_n_to_1.sv
// N:1 word mux with registered output, valid/ready on every channel, explicit or round-robin select.
// Define PIPELINED_MUX_PARITY_EN to add the registered out_parity output.
module pipelined_mux_n_to_1 #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SEL_W-1:0]   sel,
  input  logic               mode,
  output logic [WIDTH-1:0]   out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sel_err
`ifdef PIPELINED_MUX_PARITY_EN
  ,
  output logic               out_parity
`endif
);

  logic             load;
  logic             sel_ok;
  logic             found;
  logic             transfer;
  logic             hi_found;
  logic             lo_found;
  logic [SEL_W-1:0] hi_grant;
  logic [SEL_W-1:0] lo_grant;
  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] ptr_next;
  logic [WIDTH-1:0] grant_data;

  always_comb begin
    load     = ~out_valid | out_ready;
    sel_ok   = (int'(sel) < N);
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_grant = '0;
    lo_grant = '0;
    // Descending scan: the last hit is the lowest index, so hi_* is the first valid at/after
    // ptr and lo_* is the first valid overall, which is the wrap-around fallback.
    for (int i = N - 1; i >= 0; i--) begin
      if (in_valid[i] && (SEL_W'(i) >= ptr)) begin
        hi_found = 1'b1;
        hi_grant = SEL_W'(i);
      end
      if (in_valid[i]) begin
        lo_found = 1'b1;
        lo_grant = SEL_W'(i);
      end
    end
    if (!mode) begin
      found = sel_ok;
      grant = sel;
    end else begin
      found = hi_found | lo_found;
      grant = hi_found ? hi_grant : lo_grant;
    end
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (found && (grant == SEL_W'(i))) begin
        in_ready[i] = load;
        grant_data  = in[i*WIDTH +: WIDTH];
      end
    end
    transfer = |(in_ready & in_valid);
    ptr_next = (grant == SEL_W'(N - 1)) ? '0 : grant + SEL_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
      ptr       <= '0;
`ifdef PIPELINED_MUX_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else begin
      sel_err <= ~mode & ~sel_ok;
      if (load) begin
        out_valid <= transfer;
        if (transfer) begin
          out <= grant_data;
`ifdef PIPELINED_MUX_PARITY_EN
          out_parity <= ^grant_data;
`endif
        end
      end
      if (transfer && mode) begin
        ptr <= ptr_next;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_mux_n_to_1.sv
// Scoreboard bench for pipelined_mux_n_to_1: an N=4 instance checked against a reference model
// and an N=3 instance for out-of-range select.
module tb_pipelined_mux_n_to_1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic [127:0] in4 = '0;
  logic [3:0]   in_valid4 = '0;
  logic [3:0]   in_ready4;
  logic [1:0]   sel4 = '0;
  logic         mode4 = 1'b0;
  logic [31:0]  out4;
  logic         out_valid4;
  logic         out_ready4 = 1'b1;
  logic         sel_err4;

  logic [95:0]  in3 = '0;
  logic [2:0]   in_valid3 = '0;
  logic [2:0]   in_ready3;
  logic [1:0]   sel3 = '0;
  logic         mode3 = 1'b0;
  logic [31:0]  out3;
  logic         out_valid3;
  logic         out_ready3 = 1'b1;
  logic         sel_err3;

`ifdef PIPELINED_MUX_PARITY_EN
  logic         parity4;
  logic         parity3;
`endif

  int           total = 0;
  int           bad = 0;

  // Reference model of the N=4 instance
  logic [31:0]  q[$];
  logic         m_ov = 1'b0;
  int           m_ptr = 0;
  logic [3:0]   exp_ready;
  int           exp_g;
  logic         exp_xfer;
  logic         exp_load;

  always #5 clk = ~clk;

  pipelined_mux_n_to_1 #(.WIDTH(32), .N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in(in4), .in_valid(in_valid4), .in_ready(in_ready4),
    .sel(sel4), .mode(mode4), .out(out4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sel_err(sel_err4)
`ifdef PIPELINED_MUX_PARITY_EN
    , .out_parity(parity4)
`endif
  );

  pipelined_mux_n_to_1 #(.WIDTH(32), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in(in3), .in_valid(in_valid3), .in_ready(in_ready3),
    .sel(sel3), .mode(mode3), .out(out3), .out_valid(out_valid3), .out_ready(out_ready3),
    .sel_err(sel_err3)
`ifdef PIPELINED_MUX_PARITY_EN
    , .out_parity(parity3)
`endif
  );

  task automatic model_comb();
    logic found;
    int j;
    found = 1'b0;
    exp_g = 0;
    exp_load = !m_ov || out_ready4;
    if (!mode4) begin
      found = 1'b1;
      exp_g = int'(sel4);
    end else begin
      for (int k = 0; k < 4; k++) begin
        j = (m_ptr + k) % 4;
        if (!found && in_valid4[j]) begin
          found = 1'b1;
          exp_g = j;
        end
      end
    end
    exp_ready = '0;
    if (found && exp_load) exp_ready[exp_g] = 1'b1;
    exp_xfer = found && exp_load && in_valid4[exp_g];
  endtask

  task automatic advance();
    model_comb();
    @(posedge clk);
    if (exp_load) begin
      if (m_ov) void'(q.pop_front());
      if (exp_xfer) begin
        q.push_back(in4[exp_g*32 +: 32]);
        m_ov = 1'b1;
        if (mode4) m_ptr = (exp_g + 1) % 4;
      end else begin
        m_ov = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    total++;
    if (out4 !== 32'h0 || out_valid4 !== 1'b0 || sel_err4 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset4: out=%h valid=%b err=%b need 0/0/0", out4, out_valid4, sel_err4);
    end
    total++;
    if (out3 !== 32'h0 || out_valid3 !== 1'b0 || sel_err3 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset3: out=%h valid=%b err=%b need 0/0/0", out3, out_valid3, sel_err3);
    end
  endtask

  task automatic test_explicit_basic();
    mode4 = 1'b0; sel4 = 2'd2; in4[64 +: 32] = 32'hDEADBEEF; in_valid4 = 4'b0100; out_ready4 = 1'b1;
    #1 model_comb();
    total++;
    if (in_ready4 !== 4'b0100 || in_ready4 !== exp_ready) begin
      bad++;
      $display("[TB] FAIL explicit_ready: got %b need %b", in_ready4, exp_ready);
    end
    advance();
    total++;
    if (out_valid4 !== 1'b1 || out4 !== q[0] || out4 !== 32'hDEADBEEF) begin
      bad++;
      $display("[TB] FAIL explicit_out: got %h/%b need deadbeef/1", out4, out_valid4);
    end
  endtask

  task automatic test_back_pressure();
    out_ready4 = 1'b0; in4[64 +: 32] = 32'h12345678;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (in_ready4 !== 4'b0000) begin
        bad++;
        $display("[TB] FAIL bp_ready[%0d]: got %b need 0000", c, in_ready4);
      end
      advance();
      total++;
      if (out4 !== 32'hDEADBEEF || out_valid4 !== 1'b1 || out4 !== q[0]) begin
        bad++;
        $display("[TB] FAIL bp_hold[%0d]: got %h/%b need deadbeef/1", c, out4, out_valid4);
      end
    end
    out_ready4 = 1'b1;
    #1;
    total++;
    if (in_ready4 !== 4'b0100) begin
      bad++;
      $display("[TB] FAIL bp_release_ready: got %b need 0100", in_ready4);
    end
    advance();
    total++;
    if (out4 !== 32'h12345678 || out_valid4 !== 1'b1 || q.size() != 1 || out4 !== q[0]) begin
      bad++;
      $display("[TB] FAIL bp_drain_fill: got %h/%b need 12345678/1", out4, out_valid4);
    end
    in_valid4 = 4'b0000;
    advance();
    total++;
    if (out_valid4 !== 1'b0 || out_valid4 !== m_ov) begin
      bad++;
      $display("[TB] FAIL bp_empty: valid=%b need 0", out_valid4);
    end
  endtask

  task automatic test_rr_fairness();
    int seq[6] = '{0, 1, 2, 3, 0, 1};
    mode4 = 1'b1; in_valid4 = 4'b1111; out_ready4 = 1'b1;
    for (int i = 0; i < 4; i++) in4[i*32 +: 32] = 32'(i);
    for (int c = 0; c < 6; c++) begin
      #1 model_comb();
      total++;
      if (in_ready4 !== exp_ready) begin
        bad++;
        $display("[TB] FAIL rr_ready[%0d]: got %b need %b", c, in_ready4, exp_ready);
      end
      advance();
      total++;
      if (out4 !== q[0] || out4 !== 32'(seq[c]) || out_valid4 !== 1'b1) begin
        bad++;
        $display("[TB] FAIL rr_out[%0d]: got %0d need %0d", c, out4, seq[c]);
      end
    end
    in_valid4 = 4'b0000;
    advance();
  endtask

  task automatic test_rr_skip();
    in_valid4 = 4'b0001;
    advance();
    // Explicit-mode idle cycle in between must leave the pointer alone
    in_valid4 = 4'b0000; mode4 = 1'b0; sel4 = 2'd0;
    advance();
    mode4 = 1'b1; in_valid4 = 4'b1001;
    #1 model_comb();
    total++;
    if (in_ready4 !== 4'b1000 || in_ready4 !== exp_ready) begin
      bad++;
      $display("[TB] FAIL skip_ready3: got %b need 1000", in_ready4);
    end
    advance();
    total++;
    if (out4 !== 32'd3 || out4 !== q[0]) begin
      bad++;
      $display("[TB] FAIL skip_out3: got %0d need 3", out4);
    end
    #1;
    total++;
    if (in_ready4 !== 4'b0001) begin
      bad++;
      $display("[TB] FAIL skip_ready0: got %b need 0001", in_ready4);
    end
    advance();
    total++;
    if (out4 !== 32'd0 || out4 !== q[0]) begin
      bad++;
      $display("[TB] FAIL skip_out0: got %0d need 0", out4);
    end
    in_valid4 = 4'b0000; mode4 = 1'b0;
    advance();
  endtask

  task automatic test_sel_range();
    for (int i = 0; i < 3; i++) in3[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
    #1;
    total++;
    if (in_ready3 !== 3'b000) begin
      bad++;
      $display("[TB] FAIL range_ready: got %b need 000", in_ready3);
    end
    advance();
    total++;
    if (sel_err3 !== 1'b1 || out_valid3 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL range_err: err=%b valid=%b need 1/0", sel_err3, out_valid3);
    end
    sel3 = 2'd1;
    #1;
    total++;
    if (in_ready3 !== 3'b010) begin
      bad++;
      $display("[TB] FAIL range_ready1: got %b need 010", in_ready3);
    end
    advance();
    total++;
    if (sel_err3 !== 1'b0 || out_valid3 !== 1'b1 || out3 !== 32'hC0DE0001) begin
      bad++;
      $display("[TB] FAIL range_recover: err=%b valid=%b out=%h need 0/1/c0de0001",
               sel_err3, out_valid3, out3);
    end
    in_valid3 = 3'b000;
    advance();
  endtask

  task automatic test_async_reset();
    mode4 = 1'b0; sel4 = 2'd1; in4[32 +: 32] = 32'hA5A5A5A5; in_valid4 = 4'b0010; out_ready4 = 1'b1;
    advance();
    total++;
    if (out4 !== 32'hA5A5A5A5 || out_valid4 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ar_load: got %h/%b need a5a5a5a5/1", out4, out_valid4);
    end
    out_ready4 = 1'b0; in_valid4 = 4'b0000;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out4 !== 32'h0 || out_valid4 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ar_clear: got %h/%b need 0/0", out4, out_valid4);
    end
`ifdef PIPELINED_MUX_PARITY_EN
    total++;
    if (parity4 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ar_parity: got %b need 0", parity4);
    end
`endif
    q.delete();
    m_ov = 1'b0;
    m_ptr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    mode4 = 1'b1; in_valid4 = 4'b1111; out_ready4 = 1'b1;
    for (int i = 0; i < 4; i++) in4[i*32 +: 32] = 32'h100 + 32'(i);
    #1 model_comb();
    total++;
    if (in_ready4 !== 4'b0001 || in_ready4 !== exp_ready) begin
      bad++;
      $display("[TB] FAIL ar_ptr0: got %b need 0001", in_ready4);
    end
    advance();
    mode4 = 1'b0; sel4 = 2'd0; in4[0 +: 32] = 32'h00000007; in_valid4 = 4'b0001;
    advance();
    total++;
    if (out4 !== 32'h7 || out4 !== q[0] || out_valid4 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ar_reload: got %h/%b need 7/1", out4, out_valid4);
    end
`ifdef PIPELINED_MUX_PARITY_EN
    total++;
    if (parity4 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL parity7: got %b need 1", parity4);
    end
`endif
    in_valid4 = 4'b0000;
    advance();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_explicit_basic();
    test_back_pressure();
    test_rr_fairness();
    test_rr_skip();
    test_sel_range();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
